// File: rtl/coin_pkg.sv
// Purpose: shared coin codes and FSM state encoding for the coin acceptor slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package coin_pkg;

    // Codes driven onto the vending machine's 2-bit 'in' port; 2'b11 is never used.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Presentation FSM states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/coin_debounce.sv
// Purpose: condition one raw, asynchronous, bouncy slot sensor into a single-cycle rise event.
// Latency: 2 edges synchroniser + DEBOUNCE_CYCLES edges debounce; rise is combinational from the stable level.
// Backpressure: none; one rise pulse per accepted rising level.
// Ports: clk, rst (async active-high), raw (sensor) -> rise (one-cycle pulse when stable level goes 0->1).
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Any cycle of agreement restarts the count, so a bouncing input
            // never accumulates enough consecutive disagreement to toggle.
            if (sync2 != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Only the rising level marks a coin; the trailing edge is ignored.
    assign rise = stable & ~stable_d;

endmodule

// File: rtl/coin_acceptor.sv
// Purpose: debounce both coin slots, queue accepted coins, present them one at a time with idle gaps.
// Latency: raw rise to coin_code valid is 8 edges with an empty FIFO (2 sync, 4 debounce, 1 push, 1 issue).
// Backpressure: hold stalls presentation (sampled in IDLE only); a full FIFO rejects coins via return_coin.
// Ports: clk, rst (async active-high), coin5_raw, coin10_raw, hold
//        -> coin_code[1:0], return_coin (pulse), jam (pulse), fifo_count (queued coins).
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               coin5_raw,
    input  logic                               coin10_raw,
    input  logic                               hold,
    output logic [1:0]                         coin_code,
    output logic                               return_coin,
    output logic                               jam,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic             ev5;
    logic             ev10;
    logic             both;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             overflow;
    logic [1:0]       push_code;

    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [1:0]       state;
    logic [GAP_W-1:0] gap_cnt;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin5_raw),
        .rise (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin10_raw),
        .rise (ev10)
    );

    always_comb begin
        both      = ev5 & ev10;
        push_req  = ev5 ^ ev10;
        push_code = ev5 ? COIN_5 : COIN_10;
        full      = (fifo_count == CNT_W'(FIFO_DEPTH));
        // Pop coincides with the IDLE->ISSUE transition; the head is
        // captured into coin_code on the same edge.
        pop       = (state == ST_IDLE) && (fifo_count != '0) && !hold;
        // A pop frees the slot being written, so a full FIFO still accepts.
        push      = push_req && (!full || pop);
        overflow  = push_req && full && !pop;
    end

    // Storage carries no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            return_coin <= 1'b0;
            jam         <= 1'b0;
        end else begin
            return_coin <= both | overflow;
            jam         <= both;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            coin_code <= COIN_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    coin_code <= COIN_NONE;
                    if (pop) begin
                        state     <= ST_ISSUE;
                        coin_code <= mem[rd_ptr];
                    end
                end
                ST_ISSUE: begin
                    // Code is shown for exactly this one cycle, hold or not.
                    coin_code <= COIN_NONE;
                    gap_cnt   <= '0;
                    if (GAP_CYCLES == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    coin_code <= COIN_NONE;
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    coin_code <= COIN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Purpose: self-checking bench for coin_acceptor with a queue-based reference and decoupled monitor.
// Latency: checks the 8-edge raw-to-code latency on an empty FIFO.
// Backpressure: exercises hold stalls, FIFO overflow rejection and mid-issue reset.
module tb_coin_acceptor;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] coin_code;
    logic       return_coin;
    logic       jam;
    logic [2:0] fifo_count;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (DEPTH),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .hold       (hold),
        .coin_code  (coin_code),
        .return_coin(return_coin),
        .jam        (jam),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int passed = 0;

    // Reference: codes expected to be presented, in arrival order.
    logic [1:0] exp_q[$];
    int exp_ret = 0;
    int exp_jam = 0;
    int ret_seen = 0;
    int jam_seen = 0;
    int code_cyc = -1;
    int zero_run = GAP;
    logic [1:0] prev_code = 2'b00;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_code = 2'b00;
                zero_run  = GAP;
            end else begin
                if (return_coin) ret_seen++;
                if (jam) jam_seen++;
                if (coin_code != 2'b00) begin
                    code_cyc = cyc;
                    if (exp_q.size() == 0) check("unexpected_code", int'(coin_code), 0);
                    else check("code_order", int'(coin_code), int'(exp_q.pop_front()));
                    check("code_single_cycle", int'(prev_code), 0);
                    check("gap_before_code", int'(zero_run >= GAP), 1);
                    zero_run = 0;
                end else begin
                    zero_run++;
                end
                prev_code = coin_code;
            end
        end
    end

    // kind: 0 five, 1 ten, 2 both slots at once. Model assumes no pops while coins arrive.
    task automatic drop(input int kind, input int hi, input int lo);
        if (kind == 2) begin
            exp_jam++;
            exp_ret++;
        end else if (exp_q.size() >= DEPTH) begin
            exp_ret++;
        end else begin
            exp_q.push_back((kind == 1) ? 2'b10 : 2'b01);
        end
        coin5_raw  = (kind != 1);
        coin10_raw = (kind != 0);
        step(hi);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        step(lo);
    endtask

    task automatic end_test(input string t);
        check({t, "_drained"}, exp_q.size(), 0);
        check({t, "_return_pulses"}, ret_seen, exp_ret);
        check({t, "_jam_pulses"}, jam_seen, exp_jam);
        check({t, "_fifo_empty"}, int'(fifo_count), 0);
        ret_seen = 0;
        jam_seen = 0;
        exp_ret  = 0;
        exp_jam  = 0;
    endtask

    initial begin
        int rise_cyc;
        int n;
        bit found;

        step(3);
        check("rst_coin_code", int'(coin_code), 0);
        check("rst_return", int'(return_coin), 0);
        check("rst_jam", int'(jam), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        rst = 1'b0;
        step(2);

        // 1. Single coin, hold low: latency and occupancy 1 -> 0.
        exp_q.push_back(2'b01);
        code_cyc  = -1;
        coin5_raw = 1'b1;
        rise_cyc  = cyc;
        step(7);
        check("t1_fifo_one", int'(fifo_count), 1);
        check("t1_no_code_early", int'(coin_code), 0);
        step(1);
        check("t1_latency", code_cyc - rise_cyc, 8);
        check("t1_fifo_popped", int'(fifo_count), 0);
        step(2);
        coin5_raw = 1'b0;
        step(15);
        end_test("t1");

        // 2. Bounce: toggle every cycle for 12 cycles.
        for (int i = 0; i < 12; i++) begin
            coin10_raw = ~coin10_raw;
            step(1);
        end
        coin10_raw = 1'b0;
        step(20);
        check("t2_fifo_count", int'(fifo_count), 0);
        end_test("t2");

        // 3. Burst 5,10,5 under hold, then release.
        hold = 1'b1;
        drop(0, 6, 6);
        drop(1, 6, 6);
        drop(0, 6, 6);
        step(4);
        check("t3_fifo_three", int'(fifo_count), 3);
        check("t3_held_queue", exp_q.size(), 3);
        hold = 1'b0;
        step(30);
        end_test("t3");

        // 4. Overflow: five coins into a depth-4 FIFO under hold.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) drop(i % 2, 6, 6);
        step(4);
        check("t4_fifo_full", int'(fifo_count), DEPTH);
        hold = 1'b0;
        step(40);
        end_test("t4");

        // 5. Simultaneous insertion.
        drop(2, 6, 6);
        step(4);
        check("t5_fifo_count", int'(fifo_count), 0);
        end_test("t5");

        // Randomised rounds under hold, including occasional jams and overflow.
        for (int r = 0; r < 5; r++) begin
            hold = 1'b1;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                drop(($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)),
                     $urandom_range(5, 8), $urandom_range(5, 8));
            end
            step(4);
            check("rnd_fifo_level", int'(fifo_count), exp_q.size());
            hold = 1'b0;
            step(40);
            end_test("rnd");
        end

        // 6. Reset while a coin is being issued with two queued.
        hold = 1'b1;
        drop(0, 6, 6);
        drop(1, 6, 6);
        step(2);
        check("t6_fifo_two", int'(fifo_count), 2);
        hold  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (coin_code != 2'b00) found = 1'b1;
        end
        check("t6_issue_seen", int'(found), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_code", int'(coin_code), 0);
        check("t6_rst_fifo", int'(fifo_count), 0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        step(30);
        end_test("t6");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
